// File: rtl/pipe_hazard_unit_if.sv
// Hazard unit bus: ID-stage decode fields and redirect requests in,
// forwarding selects, stall/flush strobes and perf counters out.
interface pipe_hazard_unit_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
);
    logic                        id_valid;
    logic [NUM_SRC*REG_AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]          id_rs_used;
    logic [REG_AW-1:0]           id_rd;
    logic                        id_we;
    logic                        id_is_load;
    logic                        jump;
    logic                        branch_taken;
    logic [2*NUM_SRC-1:0]        fwd_sel;
    logic                        stall;
    logic                        flush_fd;
    logic                        flush_dx;
    logic                        flush_xm;
    logic [CNT_W-1:0]            stall_cnt;
    logic [CNT_W-1:0]            flush_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, jump, branch_taken,
        input  fwd_sel, stall, flush_fd, flush_dx, flush_xm, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, jump, branch_taken,
        output fwd_sel, stall, flush_fd, flush_dx, flush_xm, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Five-stage pipeline hazard controller: shadow DX/XM scoreboard, registered forwarding
// selects, load-use stall and redirect flushes. Define HAZARD_PERF_EN for stall/flush counters.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_unit_if.slave hz
);
    localparam int unsigned FWD_W = 2 * NUM_SRC;

    // MW-stage producers are covered by the write-before-read register file,
    // so only the DX and XM shadows influence forwarding and stalls.
    logic              dx_v;
    logic              dx_we;
    logic              dx_ld;
    logic [REG_AW-1:0] dx_rd;
    logic              xm_v;
    logic              xm_we;
    logic [REG_AW-1:0] xm_rd;

    logic [FWD_W-1:0]   fwd_q;
    logic [FWD_W-1:0]   fwd_d;
    logic [NUM_SRC-1:0] hit_dx;
    logic [NUM_SRC-1:0] hit_xm;
    logic               load_use;
    logic               stall_c;
    logic               flush_fd_c;
    logic               bubble_dx;

    // Per-source producer match; the youngest producer (DX) wins.
    always_comb begin
        hit_dx   = '0;
        hit_xm   = '0;
        fwd_d    = '0;
        load_use = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            hit_dx[i] = hz.id_rs_used[i] && (hz.id_rs[i*REG_AW +: REG_AW] != REG_AW'(0))
                        && dx_v && dx_we && (dx_rd == hz.id_rs[i*REG_AW +: REG_AW]);
            hit_xm[i] = hz.id_rs_used[i] && (hz.id_rs[i*REG_AW +: REG_AW] != REG_AW'(0))
                        && xm_v && xm_we && (xm_rd == hz.id_rs[i*REG_AW +: REG_AW]);
            if (hit_dx[i]) begin
                fwd_d[2*i +: 2] = 2'b01;
            end else if (hit_xm[i]) begin
                fwd_d[2*i +: 2] = 2'b10;
            end
            if (hit_dx[i] && dx_ld) begin
                load_use = 1'b1;
            end
        end
    end

    // A taken branch squashes the would-be stalled consumer, so it overrides the stall.
    assign stall_c    = hz.id_valid & load_use & ~hz.branch_taken;
    assign flush_fd_c = hz.branch_taken | (hz.jump & ~stall_c);
    assign bubble_dx  = stall_c | hz.branch_taken | ~hz.id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_v  <= 1'b0;
            dx_we <= 1'b0;
            dx_ld <= 1'b0;
            dx_rd <= '0;
            xm_v  <= 1'b0;
            xm_we <= 1'b0;
            xm_rd <= '0;
            fwd_q <= '0;
        end else begin
            if (hz.branch_taken) begin
                xm_v  <= 1'b0;
                xm_we <= 1'b0;
                xm_rd <= '0;
            end else begin
                xm_v  <= dx_v;
                xm_we <= dx_we;
                xm_rd <= dx_rd;
            end
            if (bubble_dx) begin
                dx_v  <= 1'b0;
                dx_we <= 1'b0;
                dx_ld <= 1'b0;
                dx_rd <= '0;
                fwd_q <= '0;
            end else begin
                dx_v  <= 1'b1;
                dx_we <= hz.id_we;
                dx_ld <= hz.id_is_load;
                dx_rd <= hz.id_rd;
                fwd_q <= fwd_d;
            end
        end
    end

    assign hz.fwd_sel  = fwd_q;
    assign hz.stall    = stall_c;
    assign hz.flush_fd = flush_fd_c;
    assign hz.flush_dx = hz.branch_taken;
    assign hz.flush_xm = hz.branch_taken;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters; flush_fd marks every accepted redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_fd_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = CNT_W'(0);
    assign hz.flush_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed hazard scenarios plus random traffic
// checked against an in-flight instruction queue model.
module tb_pipe_hazard_unit;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int CMAX = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ins_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ins_t       pipe_q[$];   // [0] = instruction now in EX, [1] = now in MEM
    logic [3:0] exp_fwd;
    int         exp_sc;
    int         exp_fc;

    pipe_hazard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) hz ();

    pipe_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ins(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                           input int rd, input bit we, input bit ld, input bit jmp, input bit bt);
        hz.id_valid     = v;
        hz.id_rs        = {5'(rs1), 5'(rs0)};
        hz.id_rs_used   = used;
        hz.id_rd        = 5'(rd);
        hz.id_we        = we;
        hz.id_is_load   = ld;
        hz.jump         = jmp;
        hz.branch_taken = bt;
    endtask

    task automatic model_reset();
        pipe_q = {};
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        exp_fwd = '0;
        exp_sc  = 0;
        exp_fc  = 0;
    endtask

    // Predict this cycle's strobes from the in-flight queue, check, then advance one edge.
    task automatic step();
        bit         st;
        bit         fd;
        bit         bt;
        bit         issued;
        logic [3:0] nf;
        logic [4:0] rs;
        ins_t       nx;
        #1;
        bt = hz.branch_taken;
        st = 1'b0;
        nf = '0;
        for (int i = 0; i < 2; i++) begin
            rs = hz.id_rs[i*5 +: 5];
            if (hz.id_rs_used[i] && rs != 5'd0) begin
                for (int age = 1; age >= 0; age--) begin
                    if (pipe_q[age].v && pipe_q[age].we && pipe_q[age].rd == rs) begin
                        nf[2*i +: 2] = (age == 0) ? 2'b01 : 2'b10;
                        if (age == 0 && pipe_q[age].ld) st = 1'b1;
                    end
                end
            end
        end
        st = st && hz.id_valid && !bt;
        fd = bt || (hz.jump && !st);
        chk("stall", 32'(hz.stall), 32'(st));
        chk("flush_fd", 32'(hz.flush_fd), 32'(fd));
        chk("flush_dx", 32'(hz.flush_dx), 32'(bt));
        chk("flush_xm", 32'(hz.flush_xm), 32'(bt));
        chk("fwd_sel", 32'(hz.fwd_sel), 32'(exp_fwd));
        chk("stall_cnt", 32'(hz.stall_cnt), 32'(exp_sc));
        chk("flush_cnt", 32'(hz.flush_cnt), 32'(exp_fc));
        if (PERF && st && exp_sc < CMAX) exp_sc++;
        if (PERF && fd && exp_fc < CMAX) exp_fc++;
        issued  = hz.id_valid && !st && !bt;
        exp_fwd = issued ? nf : 4'b0000;
        if (bt) pipe_q[0].v = 1'b0;
        nx = issued ? {1'b1, hz.id_rd, hz.id_we, hz.id_is_load} : '0;
        pipe_q.push_front(nx);
        void'(pipe_q.pop_back());
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_ins(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_fwd", 32'(hz.fwd_sel), 32'd0);
        chk("rst_stall", 32'(hz.stall), 32'd0);
        chk("rst_flush_fd", 32'(hz.flush_fd), 32'd0);
        chk("rst_flush_xm", 32'(hz.flush_xm), 32'd0);
        chk("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);
        rst = 1'b0;

        // RAW, ALU producer, gap 0 / 1 / 2
        set_ins(1, 1, 2, 2'b11, 3, 1, 0, 0, 0); step();
        set_ins(1, 3, 1, 2'b11, 4, 1, 0, 0, 0); step();
        chk("raw_gap0", 32'(hz.fwd_sel), 32'h1);
        set_ins(1, 1, 2, 2'b11, 3, 1, 0, 0, 0); step();
        set_ins(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); step();
        set_ins(1, 3, 1, 2'b11, 4, 1, 0, 0, 0); step();
        chk("raw_gap1", 32'(hz.fwd_sel), 32'h2);
        set_ins(1, 1, 2, 2'b11, 3, 1, 0, 0, 0); step();
        set_ins(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); step();
        set_ins(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); step();
        set_ins(1, 3, 1, 2'b11, 4, 1, 0, 0, 0); step();
        chk("raw_gap2", 32'(hz.fwd_sel), 32'h0);

        // Load-use: one stall cycle, then both sources from MEM/WB
        set_ins(1, 1, 0, 2'b01, 5, 1, 1, 0, 0); step();
        set_ins(1, 5, 5, 2'b11, 6, 1, 0, 0, 0); #1;
        chk("lu_stall", 32'(hz.stall), 32'd1);
        step(); #1;
        chk("lu_stall_once", 32'(hz.stall), 32'd0);
        step();
        chk("lu_fwd", 32'(hz.fwd_sel), 32'hA);
        chk("lu_stall_cnt", 32'(hz.stall_cnt), PERF ? 32'd1 : 32'd0);

        // Register 0 never forwards or stalls, even from a load
        set_ins(1, 1, 0, 2'b01, 0, 1, 1, 0, 0); step();
        set_ins(1, 0, 0, 2'b11, 8, 1, 0, 0, 0); #1;
        chk("r0_stall", 32'(hz.stall), 32'd0);
        step();
        chk("r0_fwd", 32'(hz.fwd_sel), 32'h0);

        // Branch taken while a load-use is pending
        set_ins(1, 1, 0, 2'b01, 7, 1, 1, 0, 0); step();
        set_ins(1, 7, 0, 2'b01, 8, 1, 0, 0, 1); #1;
        chk("br_stall", 32'(hz.stall), 32'd0);
        chk("br_flush_fd", 32'(hz.flush_fd), 32'd1);
        chk("br_flush_dx", 32'(hz.flush_dx), 32'd1);
        chk("br_flush_xm", 32'(hz.flush_xm), 32'd1);
        step();
        set_ins(1, 7, 0, 2'b01, 8, 1, 0, 0, 0); #1;
        chk("br_no_residual", 32'(hz.stall), 32'd0);
        step();
        chk("br_fwd", 32'(hz.fwd_sel), 32'h0);

        // Jump during a stall is deferred one cycle
        set_ins(1, 1, 0, 2'b01, 9, 1, 1, 0, 0); step();
        set_ins(1, 9, 0, 2'b01, 8, 1, 0, 1, 0); #1;
        chk("jmp_stall", 32'(hz.stall), 32'd1);
        chk("jmp_held", 32'(hz.flush_fd), 32'd0);
        step(); #1;
        chk("jmp_taken", 32'(hz.flush_fd), 32'd1);
        step();
        chk("jmp_flush_cnt", 32'(hz.flush_cnt), PERF ? 32'd2 : 32'd0);

        // Async reset between edges with DX holding a load
        set_ins(1, 1, 0, 2'b01, 10, 1, 1, 0, 0); step();
        set_ins(1, 10, 0, 2'b01, 8, 1, 0, 0, 0); #1;
        chk("ar_pre_stall", 32'(hz.stall), 32'd1);
        rst = 1'b1; #1;
        chk("ar_stall", 32'(hz.stall), 32'd0);
        chk("ar_fwd", 32'(hz.fwd_sel), 32'h0);
        chk("ar_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        model_reset();
        set_ins(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // Counter saturation: 20 load-use stalls with a 4-bit counter
        for (int n = 0; n < 20; n++) begin
            set_ins(1, 1, 0, 2'b01, 11, 1, 1, 0, 0); step();
            set_ins(1, 11, 2, 2'b11, 12, 1, 0, 0, 0); step();
            step();
        end
        chk("sat_stall_cnt", 32'(hz.stall_cnt), PERF ? 32'(CMAX) : 32'd0);

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            set_ins($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 9) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
